mem_wb_ctrl: RTL and testbench

Memory/writeback controller for the 16-bit pipelined RISC core. It takes the EX-stage result (`writedata_EX`, the load-select flag `wrt_dmem`, register-write info) and issues the data-memory/cache access for loads and stores. It stalls the upstream pipe until the cache reports completion, then drives the register-file write port and the forwarding bus. It is the consumer end of the EX write-control path.

---
 rtl/mem_wb_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_wb_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_ctrl.sv
// mem_wb_ctrl: memory/writeback stage controller for the 16-bit pipelined core.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_valid / ex_ready           EX result handshake (ready only in IDLE)
//   wrt_dmem, ex_mem_wr           load / store select (both set = illegal op)
//   ex_reg_wr, ex_reg_dst         register-write enable and destination
//   writedata_EX, ex_store_data   EX result (address for memory ops), store data
//   dmem_rd/wr/addr/wdata         cache request, held until done or err
//   dmem_rdata/done/err           cache response
//   wb_reg_wr/dst/data            register-file write port and forwarding bus
//   err                           sticky error flag
module mem_wb_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        wrt_dmem,
   input  logic        ex_mem_wr,
   input  logic        ex_reg_wr,
   input  logic [2:0]  ex_reg_dst,
   input  logic [15:0] writedata_EX,
   input  logic [15:0] ex_store_data,
   output logic        dmem_rd,
   output logic        dmem_wr,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_done,
   input  logic        dmem_err,
   output logic        wb_reg_wr,
   output logic [2:0]  wb_reg_dst,
   output logic [15:0] wb_reg_data,
   output logic        err
);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t      state_q, state_d;
   logic        load_q, load_d;
   logic        regwr_q, regwr_d;
   logic [2:0]  dst_q, dst_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        wb_wr_q, wb_wr_d;
   logic [2:0]  wb_dst_q, wb_dst_d;
   logic [15:0] wb_data_q, wb_data_d;
   logic        err_q, err_d;
   logic        accept;
   assign accept      = ex_valid && state_q == IDLE;
   assign ex_ready    = state_q == IDLE;
   assign dmem_rd     = state_q == ACCESS && load_q;
   assign dmem_wr     = state_q == ACCESS && !load_q;
   assign dmem_addr   = addr_q;
   assign dmem_wdata  = wdata_q;
   assign wb_reg_wr   = wb_wr_q;
   assign wb_reg_dst  = wb_dst_q;
   assign wb_reg_data = wb_data_q;
   assign err         = err_q;
   always_comb begin
      state_d   = state_q;
      load_d    = load_q;
      regwr_d   = regwr_q;
      dst_d     = dst_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wb_wr_d   = 1'b0;
      wb_dst_d  = wb_dst_q;
      wb_data_d = wb_data_q;
      err_d     = err_q;
      if (accept) begin
         if (wrt_dmem && ex_mem_wr) begin
            err_d = 1'b1;
         end else if (wrt_dmem || ex_mem_wr) begin
            state_d = ACCESS;
            load_d  = wrt_dmem;
            regwr_d = ex_reg_wr;
            dst_d   = ex_reg_dst;
            addr_d  = writedata_EX;
            wdata_d = ex_store_data;
         end else if (ex_reg_wr) begin
            wb_wr_d   = 1'b1;
            wb_dst_d  = ex_reg_dst;
            wb_data_d = writedata_EX;
         end
      end else if (state_q == ACCESS) begin
         // an error aborts the op even when done arrives in the same cycle
         if (dmem_err) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end else if (dmem_done) begin
            state_d = IDLE;
            if (load_q && regwr_q) begin
               wb_wr_d   = 1'b1;
               wb_dst_d  = dst_q;
               wb_data_d = dmem_rdata;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         load_q    <= 1'b0;
         regwr_q   <= 1'b0;
         dst_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wb_wr_q   <= 1'b0;
         wb_dst_q  <= '0;
         wb_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         load_q    <= load_d;
         regwr_q   <= regwr_d;
         dst_q     <= dst_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wb_wr_q   <= wb_wr_d;
         wb_dst_q  <= wb_dst_d;
         wb_data_q <= wb_data_d;
         err_q     <= err_d;
      end
   end
endmodule

// File: tb/tb_mem_wb_ctrl.sv
// tb_mem_wb_ctrl: directed and randomized bench for mem_wb_ctrl against a transaction-level model.
module tb_mem_wb_ctrl;
   logic        clk = 1'b0;
   logic        rst, ex_valid, ex_ready, wrt_dmem, ex_mem_wr, ex_reg_wr;
   logic [2:0]  ex_reg_dst, wb_reg_dst;
   logic [15:0] writedata_EX, ex_store_data, dmem_addr, dmem_wdata, dmem_rdata, wb_reg_data;
   logic        dmem_rd, dmem_wr, dmem_done, dmem_err, wb_reg_wr, err;
   int          npass = 0, ntot = 0, nfail = 0;
   logic        m_err;
   logic [2:0]  m_dst;
   logic [15:0] m_data;
   always #5 clk = ~clk;
   mem_wb_ctrl dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .wrt_dmem(wrt_dmem), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
      .ex_reg_dst(ex_reg_dst), .writedata_EX(writedata_EX), .ex_store_data(ex_store_data),
      .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_done(dmem_done), .dmem_err(dmem_err),
      .wb_reg_wr(wb_reg_wr), .wb_reg_dst(wb_reg_dst), .wb_reg_data(wb_reg_data), .err(err)
   );
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_reset_vals(input string t);
      chk({t, "_ready"}, ex_ready, 1);
      chk({t, "_rd"}, dmem_rd, 0);
      chk({t, "_wr"}, dmem_wr, 0);
      chk({t, "_addr"}, dmem_addr, 0);
      chk({t, "_wdata"}, dmem_wdata, 0);
      chk({t, "_wbwr"}, wb_reg_wr, 0);
      chk({t, "_wbdst"}, wb_reg_dst, 0);
      chk({t, "_wbdata"}, wb_reg_data, 0);
      chk({t, "_err"}, err, 0);
   endtask
   // One complete op: accept, optional access of dly+1 cycles, then writeback checks.
   task automatic do_op(input logic ld, input logic st, input logic rw, input logic [2:0] dst,
                        input logic [15:0] d, input logic [15:0] sd, input int dly,
                        input logic e, input logic dn, input logic [15:0] rd);
      chk("ready_pre", ex_ready, 1);
      ex_valid = 1; wrt_dmem = ld; ex_mem_wr = st; ex_reg_wr = rw;
      ex_reg_dst = dst; writedata_EX = d; ex_store_data = sd;
      tick();
      if (ld && st) begin
         m_err = 1;
         chk("ill_rd", dmem_rd, 0);
         chk("ill_wr", dmem_wr, 0);
         chk("ill_wb", wb_reg_wr, 0);
      end else if (ld || st) begin
         for (int i = 0; i <= dly; i++) begin
            chk("acc_ready", ex_ready, 0);
            chk("acc_rd", dmem_rd, ld);
            chk("acc_wr", dmem_wr, st);
            chk("acc_addr", dmem_addr, d);
            if (st) chk("acc_wdata", dmem_wdata, sd);
            chk("acc_wb", wb_reg_wr, 0);
            chk("acc_err", err, m_err);
            dmem_rdata = (i == dly) ? rd : 16'($urandom);
            dmem_done  = (i == dly) ? (e ? dn : 1'b1) : 1'b0;
            dmem_err   = (i == dly) && e;
            tick();
         end
         dmem_done = 0; dmem_err = 0;
         if (e) m_err = 1;
         else if (ld && rw) begin m_dst = dst; m_data = rd; end
         chk("mem_wb", wb_reg_wr, !e && ld && rw);
         chk("mem_rd_off", dmem_rd, 0);
         chk("mem_wr_off", dmem_wr, 0);
      end else begin
         chk("alu_wb", wb_reg_wr, rw);
         if (rw) begin m_dst = dst; m_data = d; end
      end
      ex_valid = 0; wrt_dmem = 0; ex_mem_wr = 0; ex_reg_wr = 0;
      chk("wb_dst", wb_reg_dst, m_dst);
      chk("wb_data", wb_reg_data, m_data);
      chk("err", err, m_err);
      chk("ready_post", ex_ready, 1);
   endtask
   initial begin
      rst = 1; ex_valid = 0; wrt_dmem = 0; ex_mem_wr = 0; ex_reg_wr = 0; ex_reg_dst = 0;
      writedata_EX = 0; ex_store_data = 0; dmem_rdata = 0; dmem_done = 0; dmem_err = 0;
      m_err = 0; m_dst = 0; m_data = 0;
      tick(); tick();
      rst = 0;
      chk_reset_vals("rst");
      do_op(0, 0, 1, 3'd3, 16'h1234, 16'h0, 0, 0, 0, 16'h0);
      tick();
      chk("alu_pulse_end", wb_reg_wr, 0);
      do_op(1, 0, 1, 3'd5, 16'h0040, 16'h0, 2, 0, 0, 16'hBEEF);
      tick();
      chk("load_pulse_end", wb_reg_wr, 0);
      do_op(0, 1, 1, 3'd2, 16'h0010, 16'hA5A5, 0, 0, 0, 16'hFFFF);
      do_op(1, 0, 1, 3'd6, 16'h0022, 16'h0, 1, 1, 1, 16'hDEAD);
      do_op(0, 0, 1, 3'd1, 16'h0007, 16'h0, 0, 0, 0, 16'h0);
      do_op(1, 1, 1, 3'd4, 16'h0050, 16'h1111, 0, 0, 0, 16'h0);
      tick();
      chk("ill_no_req", dmem_rd | dmem_wr, 0);
      // reset during the second access cycle of a load, with done coinciding
      ex_valid = 1; wrt_dmem = 1; ex_reg_wr = 1; ex_reg_dst = 3'd7; writedata_EX = 16'h0080;
      tick();
      chk("rst_acc1_rd", dmem_rd, 1);
      tick();
      chk("rst_acc2_rd", dmem_rd, 1);
      rst = 1; dmem_done = 1; dmem_rdata = 16'hCAFE;
      ex_valid = 0; wrt_dmem = 0; ex_reg_wr = 0;
      tick();
      rst = 0;
      m_err = 0; m_dst = 0; m_data = 0;
      chk_reset_vals("midrst");
      tick();
      dmem_done = 0;
      chk("midrst_late_done_wb", wb_reg_wr, 0);
      chk("midrst_late_done_data", wb_reg_data, 0);
      for (int k = 0; k < 60; k++) begin
         int t;
         logic ld, st;
         t  = $urandom_range(0, 19);
         ld = (t >= 8 && t < 13) || t == 19;
         st = (t >= 13 && t < 18) || t == 19;
         do_op(ld, st, 1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 11) == 0, 1'($urandom), 16'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            dmem_done = 1; dmem_rdata = 16'($urandom);
            tick();
            dmem_done = 0;
            chk("idle_done_wb", wb_reg_wr, 0);
            chk("idle_done_ready", ex_ready, 1);
            chk("idle_done_data", wb_reg_data, m_data);
         end
      end
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
